setpoint_ctrl: RTL and testbench



---
 rtl/thermo_pkg.sv | 32 +++
 rtl/setpoint_ctrl_if.sv | 25 ++
 rtl/btn_debounce.sv | 59 +++++
 rtl/setpoint_ctrl.sv | 160 ++++++++++++++++
 tb/tb_setpoint_ctrl.sv | 214 +++++++++++++++++++++
 5 files changed

// File: rtl/thermo_pkg.sv
// Shared thermostat types and default constants.
// Used by the setpoint controller and by future status/LED logic.
package thermo_pkg;

    typedef enum logic [1:0] {
        CL_OFF  = 2'd0,
        CL_HEAT = 2'd1,
        CL_COOL = 2'd2
    } climate_state_t;

    typedef enum logic [1:0] {
        PR_IDLE   = 2'd0,
        PR_DELAY  = 2'd1,
        PR_REPEAT = 2'd2,
        PR_LOCK   = 2'd3
    } press_state_t;

    localparam logic [7:0] SET_MIN_DEF  = 8'd50;
    localparam logic [7:0] SET_MAX_DEF  = 8'd90;
    localparam logic [7:0] SET_INIT_DEF = 8'd72;
    localparam logic [7:0] HYST_DEF     = 8'd2;

    // Saturating one-degree step; a step at the limit leaves the value unchanged.
    function automatic logic [7:0] step_setpoint(input logic [7:0] cur, input logic up,
                                                 input logic [7:0] lo, input logic [7:0] hi);
        if (up) begin
            return (cur < hi) ? cur + 8'd1 : cur;
        end
        return (cur > lo) ? cur - 8'd1 : cur;
    endfunction

endpackage

// File: rtl/setpoint_ctrl_if.sv
// Button/temperature bundle of the setpoint controller, plus FSM state visibility.
// No handshake: every signal is a level, sampled or updated on each rising clk edge.
interface setpoint_ctrl_if;
    import thermo_pkg::*;

    logic           btn_up;
    logic           btn_down;
    logic [7:0]     CurrentTemp;
    logic [7:0]     ChangedTemp;
    logic           heat_on;
    logic           cool_on;
    press_state_t   press_state;
    climate_state_t climate_state;

    modport slave (
        input  btn_up, btn_down, CurrentTemp,
        output ChangedTemp, heat_on, cool_on, press_state, climate_state
    );

    modport master (
        output btn_up, btn_down, CurrentTemp,
        input  ChangedTemp, heat_on, cool_on, press_state, climate_state
    );

endinterface

// File: rtl/btn_debounce.sv
// 2-FF synchroniser plus stable-sample debouncer for one raw push-button.
// The level flips after DEBOUNCE_CYCLES consecutive differing samples; rise_o pulses with it.
module btn_debounce #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
    input  logic clk,
    input  logic rst,
    input  logic btn_i,
    output logic sync_o,
    output logic level_o,
    output logic rise_o
);

    localparam int unsigned CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q, sync2_q;
    logic          level_q, level_d;
    logic          rise_q, rise_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Synchroniser is left out of reset so a button held through reset stays visible.
    always_ff @(posedge clk) begin
        sync1_q <= btn_i;
        sync2_q <= sync1_q;
    end

    always_comb begin
        level_d = level_q;
        cnt_d   = cnt_q;
        rise_d  = 1'b0;
        if (sync2_q == level_q) begin
            cnt_d = '0;
        end else if (cnt_q == CNT_LAST) begin
            level_d = sync2_q;
            rise_d  = sync2_q;
            cnt_d   = '0;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            level_q <= level_d;
            rise_q  <= rise_d;
            cnt_q   <= cnt_d;
        end
    end

    assign sync_o  = sync2_q;
    assign level_o = level_q;
    assign rise_o  = rise_q;

endmodule

// File: rtl/setpoint_ctrl.sv
// Debounced, auto-repeating, range-limited thermostat setpoint with a
// hysteretic heat/cool request FSM comparing it against the sensor temperature.
module setpoint_ctrl
    import thermo_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned REPEAT_DELAY    = 50_000_000,
    parameter int unsigned REPEAT_RATE     = 20_000_000,
    parameter logic [7:0]  SET_MIN         = SET_MIN_DEF,
    parameter logic [7:0]  SET_MAX         = SET_MAX_DEF,
    parameter logic [7:0]  SET_INIT        = SET_INIT_DEF,
    parameter logic [7:0]  HYST            = HYST_DEF
) (
    input logic            clk,
    input logic            rst,
    setpoint_ctrl_if.slave bus
);

    localparam int unsigned HOLD_MAX = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int unsigned HW       = (HOLD_MAX > 1) ? $clog2(HOLD_MAX) : 1;
    localparam logic [HW-1:0] DELAY_LAST = HW'(REPEAT_DELAY - 1);
    localparam logic [HW-1:0] RATE_LAST  = HW'(REPEAT_RATE - 1);

    logic up_sync, up_lvl, up_rise;
    logic dn_sync, dn_lvl, dn_rise;

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_up (
        .clk     (clk),
        .rst     (rst),
        .btn_i   (bus.btn_up),
        .sync_o  (up_sync),
        .level_o (up_lvl),
        .rise_o  (up_rise)
    );

    btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_dn (
        .clk     (clk),
        .rst     (rst),
        .btn_i   (bus.btn_down),
        .sync_o  (dn_sync),
        .level_o (dn_lvl),
        .rise_o  (dn_rise)
    );

    press_state_t   press_q, press_d;
    climate_state_t climate_q, climate_d;
    logic [HW-1:0]  hold_q, hold_d;
    logic           dir_up_q, dir_up_d;
    logic           ign_up_q, ign_up_d, ign_dn_q, ign_dn_d;
    logic [7:0]     setpoint_q, setpoint_d;
    logic           step_req;
    logic           up_go, dn_go, act_lvl;

    // A button already high at reset release must not step on its first accepted edge.
    always_comb begin
        ign_up_d = ign_up_q;
        ign_dn_d = ign_dn_q;
        if (up_rise || !up_sync) ign_up_d = 1'b0;
        if (dn_rise || !dn_sync) ign_dn_d = 1'b0;
    end

    assign up_go   = up_rise && !ign_up_q;
    assign dn_go   = dn_rise && !ign_dn_q;
    assign act_lvl = dir_up_q ? up_lvl : dn_lvl;

    always_ff @(posedge clk) begin
        if (rst) begin
            press_q    <= PR_IDLE;
            hold_q     <= '0;
            dir_up_q   <= 1'b0;
            ign_up_q   <= up_sync;
            ign_dn_q   <= dn_sync;
            setpoint_q <= SET_INIT;
            climate_q  <= CL_OFF;
        end else begin
            press_q    <= press_d;
            hold_q     <= hold_d;
            dir_up_q   <= dir_up_d;
            ign_up_q   <= ign_up_d;
            ign_dn_q   <= ign_dn_d;
            setpoint_q <= setpoint_d;
            climate_q  <= climate_d;
        end
    end

    always_comb begin
        press_d  = press_q;
        hold_d   = hold_q + HW'(1);
        dir_up_d = dir_up_q;
        step_req = 1'b0;
        if (up_lvl && dn_lvl) begin
            press_d = PR_LOCK;
            hold_d  = '0;
        end else begin
            case (press_q)
                PR_IDLE: begin
                    hold_d = '0;
                    if (up_go ^ dn_go) begin
                        press_d  = PR_DELAY;
                        dir_up_d = up_go;
                        step_req = 1'b1;
                    end
                end
                PR_DELAY: begin
                    if (!act_lvl) begin
                        press_d = PR_IDLE;
                        hold_d  = '0;
                    end else if (hold_q == DELAY_LAST) begin
                        press_d  = PR_REPEAT;
                        hold_d   = '0;
                        step_req = 1'b1;
                    end
                end
                PR_REPEAT: begin
                    if (!act_lvl) begin
                        press_d = PR_IDLE;
                        hold_d  = '0;
                    end else if (hold_q == RATE_LAST) begin
                        hold_d   = '0;
                        step_req = 1'b1;
                    end
                end
                default: begin
                    hold_d = '0;
                    if (!up_lvl && !dn_lvl) press_d = PR_IDLE;
                end
            endcase
        end
    end

    // Climate thresholds in 9 bits: CurrentTemp + HYST never overflows, nothing underflows.
    logic [8:0] ct9, sp9, hy9;
    assign ct9 = {1'b0, bus.CurrentTemp};
    assign sp9 = {1'b0, setpoint_q};
    assign hy9 = {1'b0, HYST};

    always_comb begin
        climate_d = climate_q;
        case (climate_q)
            CL_OFF: begin
                if (ct9 + hy9 < sp9)      climate_d = CL_HEAT;
                else if (ct9 > sp9 + hy9) climate_d = CL_COOL;
            end
            CL_HEAT: if (ct9 >= sp9) climate_d = CL_OFF;
            CL_COOL: if (ct9 <= sp9) climate_d = CL_OFF;
            default: climate_d = CL_OFF;
        endcase
    end

    always_comb begin
        setpoint_d = setpoint_q;
        if (step_req) setpoint_d = step_setpoint(setpoint_q, dir_up_d, SET_MIN, SET_MAX);
        bus.ChangedTemp   = setpoint_q;
        bus.heat_on       = (climate_q == CL_HEAT);
        bus.cool_on       = (climate_q == CL_COOL);
        bus.press_state   = press_q;
        bus.climate_state = climate_q;
    end

endmodule

// File: tb/tb_setpoint_ctrl.sv
// Directed bench for setpoint_ctrl with short debounce/repeat timing.
module tb_setpoint_ctrl;
    import thermo_pkg::*;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_cmp = 0;
    int   n_err = 0;

    setpoint_ctrl_if bus_if ();

    setpoint_ctrl #(
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (20),
        .REPEAT_RATE     (8)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    initial begin
        int gaps[5];
        logic [7:0] v;
        gaps = '{20, 8, 8, 8, 8};

        bus_if.btn_up      = 1'b0;
        bus_if.btn_down    = 1'b0;
        bus_if.CurrentTemp = 8'd72;
        rst = 1'b1;
        tick(3);
        rst = 1'b0;
        tick(1);
        chk("rst_temp", 32'(bus_if.ChangedTemp), 32'd72);
        chk("rst_heat", 32'(bus_if.heat_on), 32'd0);
        chk("rst_cool", 32'(bus_if.cool_on), 32'd0);
        chk("rst_press", 32'(bus_if.press_state), 32'(PR_IDLE));
        chk("rst_clim", 32'(bus_if.climate_state), 32'(CL_OFF));

        // 1: single clean press, step lands 7 edges after the raw edge
        bus_if.btn_up = 1'b1;
        tick(6);
        chk("t1_pre", 32'(bus_if.ChangedTemp), 32'd72);
        tick(1);
        chk("t1_step", 32'(bus_if.ChangedTemp), 32'd73);
        tick(3);
        chk("t1_hold", 32'(bus_if.ChangedTemp), 32'd73);
        chk("t1_heat", 32'(bus_if.heat_on), 32'd0);
        chk("t1_cool", 32'(bus_if.cool_on), 32'd0);
        bus_if.btn_up = 1'b0;
        tick(10);
        chk("t1_idle", 32'(bus_if.press_state), 32'(PR_IDLE));

        // 2: auto-repeat from 72
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(1);
        bus_if.btn_up = 1'b1;
        tick(7);
        chk("t2_s0", 32'(bus_if.ChangedTemp), 32'd73);
        v = 8'd73;
        for (int i = 0; i < 5; i++) begin
            tick(gaps[i] - 1);
            chk("t2_before", 32'(bus_if.ChangedTemp), 32'(v));
            tick(1);
            v = v + 8'd1;
            chk("t2_step", 32'(bus_if.ChangedTemp), 32'(v));
        end
        bus_if.btn_up = 1'b0;
        tick(12);
        chk("t2_final", 32'(bus_if.ChangedTemp), 32'd78);
        chk("t2_idle", 32'(bus_if.press_state), 32'(PR_IDLE));

        // 3: bouncy press gives exactly one step, timed from the last toggle
        bus_if.btn_up = 1'b1;
        tick(1);
        bus_if.btn_up = 1'b0;
        tick(1);
        bus_if.btn_up = 1'b1;
        tick(6);
        chk("t3_pre", 32'(bus_if.ChangedTemp), 32'd78);
        tick(1);
        chk("t3_step", 32'(bus_if.ChangedTemp), 32'd79);
        bus_if.btn_up = 1'b0;
        tick(12);
        chk("t3_once", 32'(bus_if.ChangedTemp), 32'd79);

        // 4: saturation at both limits
        bus_if.btn_up = 1'b1;
        tick(150);
        chk("t4_max", 32'(bus_if.ChangedTemp), 32'd90);
        bus_if.btn_up = 1'b0;
        tick(12);
        bus_if.btn_up = 1'b1;
        tick(10);
        chk("t4_max_again", 32'(bus_if.ChangedTemp), 32'd90);
        bus_if.btn_up = 1'b0;
        tick(12);
        bus_if.btn_down = 1'b1;
        tick(400);
        chk("t4_min", 32'(bus_if.ChangedTemp), 32'd50);
        bus_if.btn_down = 1'b0;
        tick(12);
        bus_if.btn_down = 1'b1;
        tick(10);
        chk("t4_min_again", 32'(bus_if.ChangedTemp), 32'd50);
        bus_if.btn_down = 1'b0;
        tick(12);

        // 5: both buttons lock out steps until both are released
        for (int i = 0; i < 2; i++) begin
            bus_if.btn_up = 1'b1;
            tick(10);
            bus_if.btn_up = 1'b0;
            tick(12);
        end
        chk("t5_start", 32'(bus_if.ChangedTemp), 32'd52);
        bus_if.btn_up   = 1'b1;
        bus_if.btn_down = 1'b1;
        tick(10);
        chk("t5_lock", 32'(bus_if.press_state), 32'(PR_LOCK));
        chk("t5_lock_val", 32'(bus_if.ChangedTemp), 32'd52);
        bus_if.btn_up = 1'b0;
        tick(15);
        chk("t5_still_lock", 32'(bus_if.press_state), 32'(PR_LOCK));
        chk("t5_no_step", 32'(bus_if.ChangedTemp), 32'd52);
        bus_if.btn_down = 1'b0;
        tick(12);
        chk("t5_unlock", 32'(bus_if.press_state), 32'(PR_IDLE));
        bus_if.btn_down = 1'b1;
        tick(6);
        chk("t5_pre", 32'(bus_if.ChangedTemp), 32'd52);
        tick(1);
        chk("t5_step", 32'(bus_if.ChangedTemp), 32'd51);
        bus_if.btn_down = 1'b0;
        tick(12);

        // 6: climate hysteresis around setpoint 72
        bus_if.CurrentTemp = 8'd72;
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        tick(1);
        chk("t6_sp", 32'(bus_if.ChangedTemp), 32'd72);
        bus_if.CurrentTemp = 8'd69;
        chk("t6_heat_lat", 32'(bus_if.heat_on), 32'd0);
        tick(1);
        chk("t6_heat_on", 32'(bus_if.heat_on), 32'd1);
        bus_if.CurrentTemp = 8'd71;
        tick(2);
        chk("t6_heat_hold", 32'(bus_if.heat_on), 32'd1);
        bus_if.CurrentTemp = 8'd72;
        tick(1);
        chk("t6_heat_off", 32'(bus_if.heat_on), 32'd0);
        bus_if.CurrentTemp = 8'd75;
        tick(1);
        chk("t6_cool_on", 32'(bus_if.cool_on), 32'd1);
        chk("t6_heat_excl", 32'(bus_if.heat_on), 32'd0);
        bus_if.CurrentTemp = 8'd72;
        tick(1);
        chk("t6_cool_off", 32'(bus_if.cool_on), 32'd0);
        bus_if.CurrentTemp = 8'd200;
        tick(1);
        chk("t6_cool_hi", 32'(bus_if.cool_on), 32'd1);
        rst = 1'b1;
        tick(1);
        chk("t6_rst_cool", 32'(bus_if.cool_on), 32'd0);
        chk("t6_rst_clim", 32'(bus_if.climate_state), 32'(CL_OFF));
        bus_if.CurrentTemp = 8'd72;
        rst = 1'b0;
        tick(2);

        // 7: reset while held; held button must not step after release of reset
        bus_if.btn_up = 1'b1;
        tick(30);
        chk("t7_held", 32'(bus_if.ChangedTemp), 32'd74);
        rst = 1'b1;
        tick(2);
        chk("t7_rst", 32'(bus_if.ChangedTemp), 32'd72);
        rst = 1'b0;
        tick(20);
        chk("t7_no_step", 32'(bus_if.ChangedTemp), 32'd72);
        bus_if.btn_up = 1'b0;
        tick(12);
        chk("t7_released", 32'(bus_if.ChangedTemp), 32'd72);
        bus_if.btn_up = 1'b1;
        tick(6);
        chk("t7_pre", 32'(bus_if.ChangedTemp), 32'd72);
        tick(1);
        chk("t7_step", 32'(bus_if.ChangedTemp), 32'd73);
        bus_if.btn_up = 1'b0;
        tick(12);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
